// File: rtl/ysyx_25040111_memarb_if.sv
// Bundle of the icache, LSU and downstream memory signals around the arbiter.
// Pure wiring, no latency of its own.
// Backpressure: carried by the ready/valid signals it contains.
interface ysyx_25040111_memarb_if;
    // icache side
    logic        c_arvalid;
    logic        c_arready;
    logic [31:0] c_araddr;
    logic        c_rvalid;
    // LSU side
    logic        d_arvalid;
    logic        d_awvalid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_rvalid;
    logic        d_bvalid;
    // shared read data back to both requesters
    logic [31:0] up_rdata;
    // downstream memory side
    logic        m_arvalid;
    logic        m_arready;
    logic [7:0]  m_arlen;
    logic [31:0] m_addr;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid;

    // Arbiter view: serves the requesters and masters the memory.
    modport master (
        input  c_arvalid, c_araddr,
        output c_arready, c_rvalid,
        input  d_arvalid, d_awvalid, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rvalid, d_bvalid,
        output up_rdata,
        output m_arvalid, m_arlen, m_addr, m_awvalid, m_wdata, m_wstrb,
        input  m_arready, m_rvalid, m_rdata, m_rlast, m_awready, m_bvalid
    );

    // Environment view: requesters plus the memory slave.
    modport slave (
        output c_arvalid, c_araddr,
        input  c_arready, c_rvalid,
        output d_arvalid, d_awvalid, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rvalid, d_bvalid,
        input  up_rdata,
        input  m_arvalid, m_arlen, m_addr, m_awvalid, m_wdata, m_wstrb,
        output m_arready, m_rvalid, m_rdata, m_rlast, m_awready, m_bvalid
    );
endinterface

// File: rtl/ysyx_25040111_memarb.sv
// icache/LSU memory arbiter, one transaction in flight; ARB_RR_EN selects round-robin over fixed LSU priority.
// Latency: grant is combinational in IDLE, address phase starts the next cycle, read data passes through combinationally.
// Backpressure: requesters wait on c_arready/d_ready; downstream stalls via m_arready/m_awready; read beats are never stalled.
module ysyx_25040111_memarb #(
    parameter logic [7:0] IBURST_LEN = 8'd7
) (
    input  logic                   clock,
    input  logic                   reset,
    ysyx_25040111_memarb_if.master bus
);
    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        c_req;
    logic        d_req;
    logic        grant_c;
    logic        grant_d;
    logic [7:0]  arlen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    assign c_req = bus.c_arvalid;
    assign d_req = bus.d_arvalid | bus.d_awvalid;

`ifdef ARB_RR_EN
    logic rr_icache;  // set: icache wins the next tie

    // Round-robin grant: on a tie the side not granted last wins.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && reset) begin
            if (c_req && d_req) begin
                grant_c = rr_icache;
                grant_d = !rr_icache;
            end else begin
                grant_c = c_req;
                grant_d = d_req;
            end
        end
    end

    // Pointer flips to the other side on every grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_icache <= 1'b1;
        end else if (grant_c) begin
            rr_icache <= 1'b0;
        end else if (grant_d) begin
            rr_icache <= 1'b1;
        end
    end
`else
    // Fixed grant: LSU always beats icache.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && reset) begin
            grant_d = d_req;
            grant_c = c_req && !d_req;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.c_arready = grant_c;
        bus.d_ready   = grant_d;
        bus.m_arvalid = 1'b0;
        bus.m_awvalid = 1'b0;
        bus.c_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_bvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_c) begin
                    state_nxt = I_AR;
                end else if (grant_d) begin
                    // write wins over read from the LSU
                    state_nxt = bus.d_awvalid ? D_W : D_AR;
                end
            end
            I_AR: begin
                bus.m_arvalid = 1'b1;
                if (bus.m_arready) state_nxt = I_R;
            end
            I_R: begin
                bus.c_rvalid = bus.m_rvalid;
                if (bus.m_rvalid && bus.m_rlast) state_nxt = IDLE;
            end
            D_AR: begin
                bus.m_arvalid = 1'b1;
                if (bus.m_arready) state_nxt = D_R;
            end
            D_R: begin
                // single-beat read: first beat ends it regardless of rlast
                bus.d_rvalid = bus.m_rvalid;
                if (bus.m_rvalid) state_nxt = IDLE;
            end
            D_W: begin
                bus.m_awvalid = 1'b1;
                if (bus.m_awready) state_nxt = D_B;
            end
            D_B: begin
                bus.d_bvalid = bus.m_bvalid;
                if (bus.m_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request so downstream fields stay stable for the whole transaction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            arlen_q <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (grant_c) begin
            arlen_q <= IBURST_LEN;
            addr_q  <= bus.c_araddr;
            wstrb_q <= 4'd0;
        end else if (grant_d) begin
            arlen_q <= 8'd0;
            addr_q  <= bus.d_addr;
            if (bus.d_awvalid) begin
                wdata_q <= bus.d_wdata;
                wstrb_q <= bus.d_wstrb;
            end else begin
                wstrb_q <= 4'd0;
            end
        end else if (state == D_B && bus.m_bvalid) begin
            wstrb_q <= 4'd0;
        end
    end

    assign bus.m_arlen  = arlen_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.m_wstrb  = wstrb_q;
    assign bus.up_rdata = bus.m_rdata;

endmodule

// File: tb/tb_ysyx_25040111_memarb.sv
// Directed bench for the memory arbiter; read beats go through a scoreboard queue.
// Inputs change on the falling edge, outputs are sampled 1ns later.
// The memory slave is modelled inline by the directed steps.
module tb_ysyx_25040111_memarb;
`ifdef ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    ysyx_25040111_memarb_if bus();

    ysyx_25040111_memarb #(.IBURST_LEN(8'd7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.c_arvalid = 1'b0;
        bus.c_araddr  = 32'd0;
        bus.d_arvalid = 1'b0;
        bus.d_awvalid = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.d_wstrb   = 4'd0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = 32'd0;
        bus.m_rlast   = 1'b0;
        bus.m_awready = 1'b0;
        bus.m_bvalid  = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_m_arvalid"}, bus.m_arvalid, 32'd0);
        chk({tag, "_m_awvalid"}, bus.m_awvalid, 32'd0);
        chk({tag, "_c_arready"}, bus.c_arready, 32'd0);
        chk({tag, "_d_ready"},   bus.d_ready,   32'd0);
        chk({tag, "_c_rvalid"},  bus.c_rvalid,  32'd0);
        chk({tag, "_d_rvalid"},  bus.d_rvalid,  32'd0);
        chk({tag, "_d_bvalid"},  bus.d_bvalid,  32'd0);
        chk({tag, "_m_arlen"},   bus.m_arlen,   32'd0);
        chk({tag, "_m_addr"},    bus.m_addr,    32'd0);
        chk({tag, "_m_wdata"},   bus.m_wdata,   32'd0);
        chk({tag, "_m_wstrb"},   bus.m_wstrb,   32'd0);
    endtask

    // Drive n read beats; expected data is queued as each beat is driven.
    task automatic rbeats(input int n, input int last_idx, input logic icache);
        int          seen;
        logic [31:0] d;
        logic        obs;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            d = $urandom;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = d;
            bus.m_rlast  = (i == last_idx);
            exp_q.push_back(d);
            #1;
            obs = icache ? bus.c_rvalid : bus.d_rvalid;
            if (obs === 1'b1) begin
                seen++;
                chk("rdata", bus.up_rdata, exp_q.pop_front());
            end
            chk("other_rvalid", icache ? bus.d_rvalid : bus.c_rvalid, 32'd0);
            chk("ar_dropped", bus.m_arvalid, 32'd0);
        end
        chk("beat_count", seen, n);
        chk("sb_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Complete a read whose grant happened at the previous rising edge (m_arready already high).
    task automatic run_read(input logic icache, input logic [31:0] addr);
        @(negedge clock);
        bus.c_arvalid = 1'b0;
        bus.d_arvalid = 1'b0;
        #1;
        chk("ar_valid", bus.m_arvalid, 32'd1);
        chk("ar_len", bus.m_arlen, icache ? 32'd7 : 32'd0);
        chk("ar_addr", bus.m_addr, addr);
        rbeats(icache ? 8 : 1, icache ? 7 : 0, icache);
        @(negedge clock);
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b0;
        #1;
        chk("stray_c_rvalid", bus.c_rvalid, 32'd0);
        chk("stray_d_rvalid", bus.d_rvalid, 32'd0);
        chk("idle_arvalid", bus.m_arvalid, 32'd0);
        bus.m_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clock);
        #1;
        chk_zero_outputs("rst");

        // icache burst alone, zero-wait slave
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus.c_arvalid = 1'b1;
        bus.c_araddr  = 32'h3000_0000;
        bus.m_arready = 1'b1;
        #1;
        chk("i_grant_c", bus.c_arready, 32'd1);
        chk("i_grant_d", bus.d_ready, 32'd0);
        run_read(1'b1, 32'h3000_0000);

        // LSU write with m_awready delayed 3 cycles
        @(negedge clock);
        bus.m_arready = 1'b0;
        bus.d_awvalid = 1'b1;
        bus.d_addr    = 32'h8000_0010;
        bus.d_wdata   = 32'hDEAD_BEEF;
        bus.d_wstrb   = 4'b0011;
        #1;
        chk("w_grant_d", bus.d_ready, 32'd1);
        chk("w_grant_c", bus.c_arready, 32'd0);
        @(negedge clock);
        bus.d_awvalid = 1'b0;
        bus.d_addr    = 32'hFFFF_FFFF;
        bus.d_wdata   = 32'd0;
        bus.d_wstrb   = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            bus.m_awready = (k == 3);
            #1;
            chk("w_awvalid", bus.m_awvalid, 32'd1);
            chk("w_addr", bus.m_addr, 32'h8000_0010);
            chk("w_wdata", bus.m_wdata, 32'hDEAD_BEEF);
            chk("w_wstrb", bus.m_wstrb, 32'h3);
        end
        @(negedge clock);
        bus.m_awready = 1'b0;
        #1;
        chk("w_aw_done", bus.m_awvalid, 32'd0);
        chk("w_b_wait", bus.d_bvalid, 32'd0);
        @(negedge clock);
        bus.m_bvalid = 1'b1;
        #1;
        chk("w_bvalid", bus.d_bvalid, 32'd1);
        @(negedge clock);
        bus.m_bvalid = 1'b0;
        #1;
        chk("w_b_pulse", bus.d_bvalid, 32'd0);
        chk("w_wstrb_idle", bus.m_wstrb, 32'd0);

        // simultaneous icache and LSU read, twice
        @(negedge clock);
        bus.c_arvalid = 1'b1;
        bus.c_araddr  = 32'h3000_0100;
        bus.d_arvalid = 1'b1;
        bus.d_addr    = 32'h8000_0200;
        bus.m_arready = 1'b1;
        #1;
        chk("tie1_c", bus.c_arready, {31'd0, RR});
        chk("tie1_d", bus.d_ready, {31'd0, !RR});
        run_read(RR, RR ? 32'h3000_0100 : 32'h8000_0200);
        @(negedge clock);
        bus.c_arvalid = 1'b1;
        bus.d_arvalid = 1'b1;
        #1;
        chk("tie2_c", bus.c_arready, 32'd0);
        chk("tie2_d", bus.d_ready, 32'd1);
        run_read(1'b0, 32'h8000_0200);

        // LSU read and write together: write first, read at the next IDLE
        @(negedge clock);
        bus.m_arready = 1'b1;
        bus.m_awready = 1'b1;
        bus.d_arvalid = 1'b1;
        bus.d_awvalid = 1'b1;
        bus.d_addr    = 32'h8000_0300;
        bus.d_wdata   = 32'h1234_5678;
        bus.d_wstrb   = 4'b1100;
        #1;
        chk("rw_grant", bus.d_ready, 32'd1);
        @(negedge clock);
        bus.d_awvalid = 1'b0;
        #1;
        chk("rw_no_regrant", bus.d_ready, 32'd0);
        chk("rw_awvalid", bus.m_awvalid, 32'd1);
        chk("rw_arvalid", bus.m_arvalid, 32'd0);
        chk("rw_wstrb", bus.m_wstrb, 32'hC);
        @(negedge clock);
        bus.m_bvalid = 1'b1;
        #1;
        chk("rw_bvalid", bus.d_bvalid, 32'd1);
        chk("rw_wait_ready", bus.d_ready, 32'd0);
        @(negedge clock);
        bus.m_bvalid = 1'b0;
        bus.m_awready = 1'b0;
        #1;
        chk("rw_read_grant", bus.d_ready, 32'd1);
        chk("rw_aw_idle", bus.m_awvalid, 32'd0);
        run_read(1'b0, 32'h8000_0300);

        // reset during an icache burst after 3 of 8 beats
        @(negedge clock);
        bus.c_arvalid = 1'b1;
        bus.c_araddr  = 32'h3000_0040;
        #1;
        chk("rst_grant", bus.c_arready, 32'd1);
        @(negedge clock);
        bus.c_arvalid = 1'b0;
        #1;
        chk("rst_arvalid", bus.m_arvalid, 32'd1);
        rbeats(3, -1, 1'b1);
        @(negedge clock);
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'd0;
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk_zero_outputs("midrst");
        @(negedge clock);
        reset = 1'b1;
        bus.m_arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = $urandom;
            bus.m_rlast  = (k == 4);
            #1;
            chk("orphan_c_rvalid", bus.c_rvalid, 32'd0);
            chk("orphan_arvalid", bus.m_arvalid, 32'd0);
        end
        @(negedge clock);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_25040111_memarb.md
YSYX_25040111_MEMARB -- requirements
Module: ysyx_25040111_memarb

Interface
REQ-001 SHALL have parameter IBURST_LEN, default 8'd7, AXI-style arlen used for every instruction burst (beats = IBURST_LEN+1).
REQ-002 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 SHALL have port c_arvalid  input  1  icache burst-read request.
REQ-005 SHALL have port c_arready  output  1  icache request accepted this cycle.
REQ-006 SHALL have port c_araddr  input  32  icache burst start address, block-aligned.
REQ-007 SHALL have port c_rvalid  output  1  icache read beat valid on up_rdata.
REQ-008 SHALL have port d_arvalid  input  1  LSU single-beat read request.
REQ-009 SHALL have port d_awvalid  input  1  LSU single-beat write request.
REQ-010 SHALL have port d_ready  output  1  LSU request (read or write) accepted this cycle.
REQ-011 SHALL have port d_addr  input  32  LSU read/write address.
REQ-012 SHALL have port d_wdata  input  32  LSU write data.
REQ-013 SHALL have port d_wstrb  input  4  LSU write byte strobes.
REQ-014 SHALL have port d_rvalid  output  1  LSU read beat valid on up_rdata.
REQ-015 SHALL have port d_bvalid  output  1  LSU write response, one-cycle pulse.
REQ-016 SHALL have port up_rdata  output  32  shared read data to both requesters, equals m_rdata.
REQ-017 SHALL have port m_arvalid  output  1  downstream read address valid.
REQ-018 SHALL have port m_arready  input  1  downstream read address accepted.
REQ-019 SHALL have port m_arlen  output  8  downstream burst length (IBURST_LEN or 0).
REQ-020 SHALL have port m_addr  output  32  latched address of current transaction (read or write).
REQ-021 SHALL have port m_rvalid  input  1  downstream read beat valid; always accepted (no backpressure).
REQ-022 SHALL have port m_rdata  input  32  downstream read data.
REQ-023 SHALL have port m_rlast  input  1  last beat of downstream read.
REQ-024 SHALL have port m_awvalid  output  1  downstream write address+data valid (single combined channel).
REQ-025 SHALL have port m_awready  input  1  downstream write accepted.
REQ-026 SHALL have port m_wdata  output  32  latched write data.
REQ-027 SHALL have port m_wstrb  output  4  latched write strobes; 4'b0 outside writes.
REQ-028 SHALL have port m_bvalid  input  1  downstream write response.

Function
REQ-029 SHALL implement FSM states IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B; exactly one transaction outstanding at any time.
REQ-030 SHALL, in IDLE only, assert exactly one of c_arready/d_ready combinationally in the same cycle as its valid, latch address/data/strobes, and enter I_AR, D_AR or D_W next cycle.
REQ-031 SHALL give d_awvalid priority over d_arvalid when both asserted.
REQ-032 SHALL hold m_arvalid high in I_AR/D_AR with stable m_addr/m_arlen until m_arready, then move to I_R/D_R.
REQ-033 SHALL drive m_arlen = IBURST_LEN for I_AR, 8'd0 for D_AR.
REQ-034 SHALL set c_rvalid = m_rvalid in I_R, d_rvalid = m_rvalid in D_R, both 0 elsewhere; beats arriving in other states are discarded.
REQ-035 SHALL leave I_R on the beat with m_rlast, and D_R on its first beat, returning to IDLE; next grant no earlier than the following cycle.
REQ-036 SHALL hold m_awvalid high in D_W until m_awready, then enter D_B; in D_B pulse d_bvalid for the cycle m_bvalid is high and return to IDLE.
REQ-037 SHALL accept m_arready/m_awready in the same cycle valid is first raised (zero-wait slave gives 1-cycle address phase).

Reset
REQ-038 SHALL, while reset is low at a clock edge, enter IDLE, clear m_arvalid, m_awvalid, c_rvalid, d_rvalid, d_bvalid, c_arready, d_ready, m_wstrb, m_arlen, m_addr, m_wdata to 0, and set the RR pointer to favour icache; reset mid-transaction abandons it without any upstream response.

Configuration
REQ-039 SHALL, with macro ARB_RR_EN defined, arbitrate icache vs LSU round-robin: on simultaneous requests in IDLE grant the requester not granted last; pointer updates on every grant.
REQ-040 SHALL, with ARB_RR_EN undefined, use fixed priority LSU over icache and contain no pointer register.

Verification
REQ-041 SHALL cover: c_araddr=0x3000_0000 alone, zero-wait slave -> m_arvalid 1 cycle with m_arlen=7, 8 c_rvalid beats, IDLE after rlast.
REQ-042 SHALL cover: d_awvalid with d_addr=0x8000_0010, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, m_awready delayed 3 cycles -> m_awvalid held 4 cycles with stable fields, one d_bvalid pulse on m_bvalid.
REQ-043 SHALL cover: c_arvalid and d_arvalid same cycle twice in a row -> RR build grants icache then LSU; fixed build grants LSU both times.
REQ-044 SHALL cover: d_arvalid and d_awvalid together -> write granted, d_ready once, read waits for next IDLE.
REQ-045 SHALL cover: reset low during I_R after 3 of 8 beats -> IDLE next cycle, all outputs 0, remaining m_rvalid beats produce no c_rvalid.
